// File: rtl/iir_pkg.sv
// Shared definitions for the sequential biquad IIR filter.
// Holds default word/fraction/guard widths, the FSM state encoding and the
// per-section coefficient index constants (coefficient address = 5*s + index).
package iir_pkg;

  localparam int unsigned DefN = 24;
  localparam int unsigned DefF = 14;
  localparam int unsigned DefG = 4;

  localparam int unsigned CoefA1     = 0;
  localparam int unsigned CoefA2     = 1;
  localparam int unsigned CoefB0     = 2;
  localparam int unsigned CoefB1     = 3;
  localparam int unsigned CoefB2     = 4;
  localparam int unsigned CoefPerSec = 5;

  typedef enum logic [2:0] {
    StIdle,
    StA1,
    StA2,
    StB0,
    StB1,
    StB2,
    StUpd,
    StDone
  } state_e;

endpackage

// File: rtl/iir_biquad_seq_if.sv
// Sample/result stream and coefficient write bus of iir_biquad_seq.
//   in_valid/in_ready/in_data     : input sample handshake (u[k])
//   out_valid/out_ready/out_data  : output result handshake (y[k])
//   coef_we/coef_addr/coef_wdata  : coefficient write port
// master = producer/consumer side, slave = filter side.
interface iir_biquad_seq_if #(
  parameter int unsigned N       = 24,
  parameter int unsigned NUM_SEC = 2
);
  localparam int unsigned CoefAW = $clog2(5 * NUM_SEC);

  logic                in_valid;
  logic                in_ready;
  logic signed [N-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic signed [N-1:0] out_data;
  logic                coef_we;
  logic [CoefAW-1:0]   coef_addr;
  logic signed [N-1:0] coef_wdata;

  modport master (
    output in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/iir_mac.sv
// Multiply/accumulate/narrow datapath of the biquad filter (combinational).
//   coef, operand : N-bit signed multiplicands
//   x             : section input, used as accumulator base when load_x
//   acc           : current accumulator (N+G bits)
//   load_x        : base = x (A1 step); load_zero : base = 0 (B0 step)
//   acc_next      : base + ((coef*operand) >>> F), kept to N+G bits
//   narrow, ovf   : acc_next reduced to N bits and its overflow indication
// Macro IIR_SAT_EN: defined -> narrowing clamps and ovf reports clamping;
// undefined -> narrowing wraps (low N bits) and ovf is 0.
module iir_mac #(
  parameter int unsigned N = 24,
  parameter int unsigned F = 14,
  parameter int unsigned G = 4
) (
  input  logic signed [N-1:0]   coef,
  input  logic signed [N-1:0]   operand,
  input  logic signed [N-1:0]   x,
  input  logic signed [N+G-1:0] acc,
  input  logic                  load_x,
  input  logic                  load_zero,
  output logic signed [N+G-1:0] acc_next,
  output logic signed [N-1:0]   narrow,
  output logic                  ovf
);
  localparam int unsigned AW = N + G;

  logic signed [2*N-1:0] prod;
  logic [AW-1:0]         prod_sh;
  logic [AW-1:0]         base;

  always_comb begin
    prod    = $signed({{N{coef[N-1]}}, coef}) * $signed({{N{operand[N-1]}}, operand});
    prod_sh = AW'(prod >>> F);
    if (load_x) begin
      base = {{G{x[N-1]}}, x};
    end else if (load_zero) begin
      base = '0;
    end else begin
      base = acc;
    end
    acc_next = $signed(base + prod_sh);
  end

`ifdef IIR_SAT_EN
  // Value fits in N bits only if the top G+1 bits are all equal.
  always_comb begin
    ovf = !((&acc_next[AW-1:N-1]) || !(|acc_next[AW-1:N-1]));
    if (ovf) begin
      narrow = acc_next[AW-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end else begin
      narrow = acc_next[N-1:0];
    end
  end
`else
  always_comb begin
    ovf    = 1'b0;
    narrow = acc_next[N-1:0];
  end
`endif

endmodule

// File: rtl/iir_biquad_seq.sv
// Sequential cascade of NUM_SEC direct-form-II biquad sections sharing one MAC.
// Per section: f = x + a1*f1 + a2*f2, y = b0*f + b1*f1 + b2*f2, then shift state.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   bus (slave)    : input/output streams and coefficient write port
//   busy           : 1 whenever the FSM is not idle
//   sat_flag       : sticky narrowing-overflow flag (0 unless IIR_SAT_EN)
// Macro IIR_SAT_EN selects saturating narrowing (see iir_mac).
module iir_biquad_seq import iir_pkg::*; #(
  parameter int unsigned N       = DefN,
  parameter int unsigned F       = DefF,
  parameter int unsigned NUM_SEC = 2,
  parameter int unsigned G       = DefG
) (
  input  logic              clk,
  input  logic              reset_n,
  iir_biquad_seq_if.slave   bus,
  output logic              busy,
  output logic              sat_flag
);
  localparam int unsigned NumCoef = CoefPerSec * NUM_SEC;
  localparam int unsigned CoefAW  = $clog2(NumCoef);
  localparam int unsigned SecW    = (NUM_SEC > 1) ? $clog2(NUM_SEC) : 1;

  state_e                state_q, state_d;
  logic [SecW-1:0]       sec_q;
  // Holds the current section's input and is overwritten with its output y.
  logic signed [N-1:0]   xy_q;
  logic signed [N-1:0]   f_q;
  logic signed [N+G-1:0] acc_q;
  logic signed [N-1:0]   f1_q [NUM_SEC];
  logic signed [N-1:0]   f2_q [NUM_SEC];
  logic signed [N-1:0]   coef_q [NumCoef];
  logic signed [N-1:0]   out_data_q;
  logic                  out_valid_q;

  logic [2:0]            coef_idx;
  logic [CoefAW-1:0]     rd_addr;
  logic signed [N-1:0]   operand;
  logic                  load_x, load_zero;
  logic signed [N+G-1:0] acc_next;
  logic signed [N-1:0]   narrow;
  logic                  ovf;
  logic                  coef_wr;
  logic                  last_sec;

  assign last_sec = (sec_q == SecW'(NUM_SEC - 1));
  assign coef_wr  = bus.coef_we && (state_q == StIdle) && (32'(bus.coef_addr) < NumCoef);

  // Operand/coefficient selection for the single multiply of each step.
  always_comb begin
    coef_idx  = 3'(CoefA1);
    operand   = '0;
    load_x    = 1'b0;
    load_zero = 1'b0;
    case (state_q)
      StA1: begin coef_idx = 3'(CoefA1); operand = f1_q[sec_q]; load_x = 1'b1; end
      StA2: begin coef_idx = 3'(CoefA2); operand = f2_q[sec_q]; end
      StB0: begin coef_idx = 3'(CoefB0); operand = f_q; load_zero = 1'b1; end
      StB1: begin coef_idx = 3'(CoefB1); operand = f1_q[sec_q]; end
      StB2: begin coef_idx = 3'(CoefB2); operand = f2_q[sec_q]; end
      default: ;
    endcase
    rd_addr = CoefAW'(CoefPerSec * 32'(sec_q) + 32'(coef_idx));
  end

  iir_mac #(
    .N(N),
    .F(F),
    .G(G)
  ) u_mac (
    .coef      (coef_q[rd_addr]),
    .operand   (operand),
    .x         (xy_q),
    .acc       (acc_q),
    .load_x    (load_x),
    .load_zero (load_zero),
    .acc_next  (acc_next),
    .narrow    (narrow),
    .ovf       (ovf)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.in_valid) state_d = StA1;
      StA1:   state_d = StA2;
      StA2:   state_d = StB0;
      StB0:   state_d = StB1;
      StB1:   state_d = StB2;
      StB2:   state_d = StUpd;
      StUpd:  state_d = last_sec ? StDone : StA1;
      StDone: if (out_valid_q && bus.out_ready) state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      sec_q       <= '0;
      xy_q        <= '0;
      f_q         <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NUM_SEC; i++) begin
        f1_q[i] <= '0;
        f2_q[i] <= '0;
      end
      for (int i = 0; i < NumCoef; i++) coef_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (coef_wr) coef_q[bus.coef_addr] <= bus.coef_wdata;
      case (state_q)
        StIdle: if (bus.in_valid) begin
          xy_q  <= bus.in_data;
          sec_q <= '0;
        end
        StA1, StB0, StB1: acc_q <= acc_next;
        StA2: begin
          acc_q <= acc_next;
          f_q   <= narrow;
        end
        StB2: begin
          acc_q <= acc_next;
          xy_q  <= narrow;
        end
        StUpd: begin
          f2_q[sec_q] <= f1_q[sec_q];
          f1_q[sec_q] <= f_q;
          if (!last_sec) sec_q <= sec_q + 1'b1;
        end
        StDone: begin
          // Result is presented one cycle after entering DONE.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= xy_q;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IIR_SAT_EN
  logic sat_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_q <= 1'b0;
    end else if (ovf && (state_q == StA2 || state_q == StB2)) begin
      sat_q <= 1'b1;
    end
  end
  assign sat_flag = sat_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf;
  assign sat_flag   = 1'b0;
`endif

  assign bus.in_ready  = (state_q == StIdle);
  assign busy          = (state_q != StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule
